// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Optional trap build: DCACHE_MISALIGN_TRAP_EN (see dcache_ctrl).
package dcache_pkg;

  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 4;   // 16-byte block
  localparam int BYTE_BITS   = 2;
  localparam int WORD_BITS   = OFFSET_BITS - BYTE_BITS;

  // Access-width encodings, shared with the load-extension stage.
  localparam logic [2:0] FUNC_B  = 3'b000;
  localparam logic [2:0] FUNC_H  = 3'b001;
  localparam logic [2:0] FUNC_W  = 3'b010;
  localparam logic [2:0] FUNC_BU = 3'b100;
  localparam logic [2:0] FUNC_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} dc_state_e;

  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [2:0]           func;
    logic [BYTE_BITS-1:0] byte_off;
  } cpu_req_t;

  function automatic logic is_misaligned(input logic [2:0] func,
                                         input logic [BYTE_BITS-1:0] byte_off);
    logic is_half;
    logic is_word;
    is_half = (func == FUNC_H) || (func == FUNC_HU);
    is_word = (func == FUNC_W);
    return (is_half && byte_off[0]) || (is_word && (byte_off != '0));
  endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Byte-lane store merge: lays the right-aligned store data into the old word.
// Halfword/word stores land on the aligned lane, ignoring low offset bits.
module store_merge
  import dcache_pkg::*;
(
  input  logic [WORD_W-1:0]    old_word,
  input  logic [WORD_W-1:0]    writedata,
  input  logic [2:0]           func,
  input  logic [BYTE_BITS-1:0] byte_off,
  output logic [WORD_W-1:0]    new_word
);

  logic unused_func;
  assign unused_func = func[2];

  always_comb begin
    new_word = old_word;
    case (func[1:0])
      2'b00:   new_word[{byte_off, 3'b000} +: 8]        = writedata[7:0];
      2'b01:   new_word[{byte_off[1], 4'b0000} +: 16]   = writedata[15:0];
      default: new_word                                 = writedata;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_MISALIGN_TRAP_EN to add the 'misaligned' trap output.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS     = 3,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              read,
  input  logic                              write,
  input  logic [2:0]                        func,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [WORD_W-1:0]                 writedata,
  output logic [WORD_W-1:0]                 readdata,
  output logic                              busywait,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-OFFSET_BITS-1:0]     mem_address,
  output logic [WORDS_PER_LINE*WORD_W-1:0]  mem_writedata,
  input  logic [WORDS_PER_LINE*WORD_W-1:0]  mem_readdata,
  input  logic                              mem_busywait
`ifdef DCACHE_MISALIGN_TRAP_EN
  ,
  output logic                              misaligned
`endif
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int LINE_W = WORDS_PER_LINE * WORD_W;
  localparam int TAG_W  = ADDR_W - OFFSET_BITS - INDEX_BITS;

  logic [LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] fill_q;

  dc_state_e state_q, state_d;

  cpu_req_t              req;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] idx;
  logic [WORD_BITS-1:0]  word_sel;
  logic [LINE_W-1:0]     line, line_new;
  logic [WORD_W-1:0]     cur_word, merged;
  logic                  trap, active, hit, hit_write, miss;

  assign req      = '{rd: read, wr: write, func: func, byte_off: address[BYTE_BITS-1:0]};
  assign tag      = address[ADDR_W-1 -: TAG_W];
  assign idx      = address[OFFSET_BITS +: INDEX_BITS];
  assign word_sel = address[BYTE_BITS +: WORD_BITS];
  assign line     = data_q[idx];
  assign cur_word = line[{word_sel, 5'b00000} +: WORD_W];

`ifdef DCACHE_MISALIGN_TRAP_EN
  assign trap       = (req.rd || req.wr) && is_misaligned(req.func, req.byte_off);
  assign misaligned = trap;
`else
  assign trap = 1'b0;
`endif

  // A trapped access behaves as if no request were present.
  assign active    = (req.rd || req.wr) && !trap;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign miss      = (state_q == IDLE) && active && !hit;
  assign hit_write = (state_q == IDLE) && active && hit && req.wr;

  store_merge u_merge (
    .old_word (cur_word),
    .writedata(writedata),
    .func     (req.func),
    .byte_off (req.byte_off),
    .new_word (merged)
  );

  always_comb begin
    line_new = line;
    line_new[{word_sel, 5'b00000} +: WORD_W] = merged;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss) state_d = dirty_q[idx] ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!mem_busywait) state_d = ALLOCATE;
      ALLOCATE:  if (!mem_busywait) state_d = FILL;
      FILL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = address[ADDR_W-1:OFFSET_BITS];
    mem_writedata = line;
    readdata      = '0;
    unique case (state_q)
      IDLE: begin
        busywait = miss;
        if (active && hit && !req.wr)
          readdata = cur_word >> {req.byte_off, 3'b000};
      end
      WRITEBACK: begin
        busywait    = 1'b1;
        mem_write   = 1'b1;
        mem_address = {tag_q[idx], idx};
      end
      ALLOCATE: begin
        busywait = 1'b1;
        mem_read = 1'b1;
      end
      FILL:    busywait = 1'b1;
      default: busywait = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == FILL) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (hit_write) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == ALLOCATE && !mem_busywait) fill_q <= mem_readdata;
    if (state_q == FILL) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag;
    end else if (hit_write) begin
      data_q[idx] <= line_new;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed plan steps plus random traffic
// checked against a flat-memory view and a tag/valid/dirty occupancy model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         reset, read, write;
  logic [2:0]   func;
  logic [31:0]  address, writedata, readdata;
  logic         busywait, mem_read, mem_write, mem_busywait;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
`ifdef DCACHE_MISALIGN_TRAP_EN
  logic         misaligned;
`endif

  int n_cmp = 0, n_err = 0;

  // memory model state
  logic [127:0] mem [logic [27:0]];
  int           nrd = 0, nwr = 0, overlap = 0;
  logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  // reference: CPU-visible words not yet in backing memory, plus line occupancy
  logic [31:0]  ref_w [logic [29:0]];
  bit           rv [8];
  bit           rdy [8];
  logic [24:0]  rt [8];

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .func(func),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    logic [31:0] x;
    x = {2'b00, wa} * 32'h9E37_79B1;
    return x ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] blk_of(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return {init_word({a, 2'd3}), init_word({a, 2'd2}), init_word({a, 2'd1}), init_word({a, 2'd0})};
  endfunction

  function automatic logic [31:0] cpu_word(input logic [29:0] wa);
    logic [127:0] b;
    if (ref_w.exists(wa)) return ref_w[wa];
    b = blk_of(wa[29:2]);
    return b[32*wa[1:0] +: 32];
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] f, input logic [1:0] b);
    logic [31:0] r;
    int lo;
    r = old;
    if (f[1:0] == 2'b00) begin
      r[8*b +: 8] = wd[7:0];
    end else if (f[1:0] == 2'b01) begin
      lo = b[1] ? 2 : 0;
      r[8*lo +: 8]     = wd[7:0];
      r[8*(lo+1) +: 8] = wd[15:8];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: random latency per transfer; completes when mem_busywait is seen low.
  initial begin : memory_model
    int  cnt;
    bit  busy;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) overlap++;
      mem_readdata = {$urandom, $urandom, $urandom, $urandom};
      if (!(mem_read || mem_write)) begin
        busy = 1'b0;
        mem_busywait = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = $urandom_range(0, 3);
        end else begin
          cnt--;
        end
        if (cnt <= 0) begin
          busy = 1'b0;
          mem_busywait = 1'b0;
          if (mem_write) begin
            mem[mem_address] = mem_writedata;
            last_wr_addr = mem_address;
            last_wr_data = mem_writedata;
            nwr++;
          end else begin
            mem_readdata = blk_of(mem_address);
            last_rd_addr = mem_address;
            nrd++;
          end
        end else begin
          mem_busywait = 1'b1;
        end
      end
    end
  end

  task automatic ref_reset();
    ref_w.delete();
    for (int i = 0; i < 8; i++) begin
      rv[i] = 1'b0;
      rdy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  // One CPU access; leaves the request asserted so a following access is back-to-back.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] got);
    int          idx, cyc, rd0, wr0;
    logic [24:0] t;
    bit          hit, mis, exp_wb;
    logic [31:0] w;
    idx = int'(a[6:4]);
    t   = a[31:7];
    hit = rv[idx] && (rt[idx] == t);
    mis = 1'b0;
`ifdef DCACHE_MISALIGN_TRAP_EN
    mis = (((f == FUNC_H) || (f == FUNC_HU)) && a[0]) || ((f == FUNC_W) && (a[1:0] != 2'b00));
`endif
    exp_wb = !hit && rv[idx] && rdy[idx];
    w   = cpu_word(a[31:2]);
    rd0 = nrd;
    wr0 = nwr;
    @(posedge clk); #1;
    read = rd; write = wr; func = f; address = a; writedata = wd;
    @(negedge clk); #1;
    cyc = 0;
    while (busywait && cyc < 64) begin
      @(negedge clk); #1;
      cyc++;
    end
    got = readdata;
    chk({tag, " timeout"}, busywait, 1'b0);
    chk({tag, " no-stall"}, cyc == 0, hit || mis);
`ifdef DCACHE_MISALIGN_TRAP_EN
    chk({tag, " misaligned"}, misaligned, mis);
`endif
    if (mis) begin
      chk({tag, " rd count"}, nrd - rd0, 0);
      chk({tag, " wr count"}, nwr - wr0, 0);
    end else begin
      chk({tag, " rd count"}, nrd - rd0, hit ? 0 : 1);
      chk({tag, " wr count"}, nwr - wr0, exp_wb ? 1 : 0);
      if (rd && !wr) chk({tag, " readdata"}, readdata, w >> (8 * a[1:0]));
      if (!hit) begin
        rv[idx] = 1'b1;
        rt[idx] = t;
        rdy[idx] = 1'b0;
      end
      if (wr) begin
        ref_w[a[31:2]] = ref_merge(w, wd, f, a[1:0]);
        rdy[idx] = 1'b1;
      end
    end
  endtask

  initial begin : stimulus
    logic [31:0] got;
    logic [2:0]  rfun [5];
    int          cyc, op;
    logic [31:0] a;
    rfun[0] = FUNC_B; rfun[1] = FUNC_H; rfun[2] = FUNC_W; rfun[3] = FUNC_BU; rfun[4] = FUNC_HU;

    reset = 1'b1; read = 1'b0; write = 1'b0; func = FUNC_W; address = '0; writedata = '0;
    mem[28'h4] = {init_word(30'h13), init_word(30'h12), init_word(30'h11), 32'h1122_3344};
    ref_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("reset busywait", busywait, 1'b0);
    chk("reset mem_read", mem_read, 1'b0);
    chk("reset mem_write", mem_write, 1'b0);
    chk("reset readdata", readdata, 32'h0);

    // plan 1/2: cold miss, then back-to-back hit
    access(1, 0, FUNC_W, 32'h40, 32'h0, "lw 40", got);
    chk("lw 40 value", got, 32'h1122_3344);
    chk("lw 40 mem_address", last_rd_addr, 28'h4);
    access(1, 0, FUNC_BU, 32'h42, 32'h0, "lbu 42", got);
    chk("lbu 42 value", got, 32'h0000_1122);

    // plan 3: byte store then read back
    access(0, 1, FUNC_B, 32'h41, 32'h0000_00AB, "sb 41", got);
    access(1, 0, FUNC_W, 32'h40, 32'h0, "lw 40 after sb", got);
    chk("lw 40 merged", got, 32'h1122_AB44);
    idle();

    // plan 4: conflicting tag forces writeback then fill
    access(1, 0, FUNC_W, 32'hC0, 32'h0, "lw c0", got);
    chk("wb address", last_wr_addr, 28'h4);
    chk("wb word0", last_wr_data[31:0], 32'h1122_AB44);
    chk("refill address", last_rd_addr, 28'hC);
    idle();

    // plan 5: reset while allocating
    @(posedge clk); #1;
    read = 1'b1; write = 1'b0; func = FUNC_W; address = 32'h140;
    cyc = 0;
    while (!mem_read && cyc < 64) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("alloc reached", mem_read, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset in alloc mem_read", mem_read, 1'b0);
    reset = 1'b0; read = 1'b0;
    ref_reset();
    access(1, 0, FUNC_W, 32'h40, 32'h0, "lw 40 after reset", got);
    chk("lw 40 after reset value", got, 32'h1122_AB44);
    idle();

    // plan 6: misaligned halfword store (traps when enabled, forced-aligned otherwise)
    access(0, 1, FUNC_H, 32'h43, 32'h0000_BEEF, "sh 43", got);
    access(1, 0, FUNC_W, 32'h40, 32'h0, "lw 40 after sh", got);
`ifdef DCACHE_MISALIGN_TRAP_EN
    chk("sh 43 line unchanged", got, 32'h1122_AB44);
`else
    chk("sh 43 forced lanes", got, 32'hBEEF_AB44);
`endif
    idle();

    // random traffic over 4 tags x 8 sets
    for (int i = 0; i < 300; i++) begin
      a  = {23'b0, 9'($urandom_range(0, 511))};
      op = $urandom_range(0, 3);
      if (op == 0)
        access(0, 1, rfun[$urandom_range(0, 2)], a, $urandom, "rand sw", got);
      else if (op == 1)
        access(1, 1, rfun[$urandom_range(0, 2)], a, $urandom, "rand rw", got);
      else
        access(1, 0, rfun[$urandom_range(0, 4)], a, 32'h0, "rand ld", got);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    chk("single mem request", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
